// File: rtl/multi_cnt_pkg.sv
// rtl/multi_cnt_pkg.sv - shared state and mode encodings for the multi-channel counter
package multi_cnt_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/cnt_channel.sv
// rtl/cnt_channel.sv - one programmable counter channel with IDLE/RUN/DONE control
module cnt_channel
  import multi_cnt_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 mode_i,
  input  logic [CNT_WIDTH-1:0] cnt_val_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 idle_o,
  output logic                 run_o,
  output logic                 done_o
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] target;
  logic                 mode;

  // State, counter and latched target/mode; stop outranks terminal count and reload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      target <= '0;
      mode   <= MODE_ONESHOT;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start_i) begin
            target <= cnt_val_i;
            mode   <= mode_i;
            state  <= (cnt_val_i != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == target - ONE) begin
            state <= ST_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        ST_DONE: begin
          cnt <= '0;
          if (stop_i) begin
            state <= ST_IDLE;
          end else if (mode == MODE_PERIODIC) begin
            // A zero target in periodic mode stays in DONE so done_o is held high.
            state <= (target != '0) ? ST_RUN : ST_DONE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign cnt_o  = cnt;
  assign idle_o = (state == ST_IDLE);
  assign run_o  = (state == ST_RUN);
  assign done_o = (state == ST_DONE);

endmodule

// File: rtl/multi_cnt_ctrl.sv
// rtl/multi_cnt_ctrl.sv - NUM_CH independent counter channels behind one top
module multi_cnt_ctrl
  import multi_cnt_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int NUM_CH    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           start_i,
  input  logic [NUM_CH-1:0]           stop_i,
  input  logic [NUM_CH-1:0]           mode_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0] cnt_val_i,
  output logic [NUM_CH*CNT_WIDTH-1:0] cnt_o,
  output logic [NUM_CH-1:0]           idle_o,
  output logic [NUM_CH-1:0]           run_o,
  output logic [NUM_CH-1:0]           done_o,
  output logic                        any_done_o,
  output logic                        all_idle_o
);

  // One channel per bit of the control buses; packed count buses sliced per channel.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    cnt_channel #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start_i[k]),
      .stop_i   (stop_i[k]),
      .mode_i   (mode_i[k]),
      .cnt_val_i(cnt_val_i[k*CNT_WIDTH +: CNT_WIDTH]),
      .cnt_o    (cnt_o[k*CNT_WIDTH +: CNT_WIDTH]),
      .idle_o   (idle_o[k]),
      .run_o    (run_o[k]),
      .done_o   (done_o[k])
    );
  end

  assign any_done_o = |done_o;
  assign all_idle_o = &idle_o;

endmodule
